// File: rtl/btn_debounce_edge_if.sv
// Pushbutton debouncer bus: raw button in, debounced level and edge pulses out.
// Shared by the debouncer (slave) and whatever drives the button (master).
interface btn_debounce_edge_if;
  logic btn_in;
  logic level;
  logic f_edge;
  logic r_edge;
  logic bouncing;

  modport master (
    output btn_in,
    input  level,
    input  f_edge,
    input  r_edge,
    input  bouncing
  );

  modport slave (
    input  btn_in,
    output level,
    output f_edge,
    output r_edge,
    output bouncing
  );
endinterface

// File: rtl/btn_debounce_edge.sv
// Active-low pushbutton debouncer with registered press/release pulses.
// Define DEBOUNCE_AUTOREPEAT_EN to add auto-repeat press pulses while held.
module btn_debounce_edge #(
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input logic              clk,
  input logic              rst_n,
  btn_debounce_edge_if.slave bus
);

  typedef enum logic [1:0] {
    S_HIGH,
    S_CHK_LOW,
    S_LOW,
    S_CHK_HIGH
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

  logic        sync1_q;
  logic        sync2_q;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        f_q, f_d;
  logic        r_q, r_d;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  // Reload value assumes REPEAT_PERIOD <= REPEAT_DELAY.
  localparam logic [25:0] RPT_FIRE   = 26'(REPEAT_DELAY - 1);
  localparam logic [25:0] RPT_RELOAD = 26'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [25:0] rpt_q, rpt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_HIGH;
      cnt_q   <= '0;
      level_q <= 1'b1;
      f_q     <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      sync1_q <= bus.btn_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      f_q     <= f_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    f_d     = 1'b0;
    r_d     = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    rpt_d   = '0;
`endif
    unique case (state_q)
      S_HIGH: begin
        if (!sync2_q) begin
          state_d = S_CHK_LOW;
          cnt_d   = 16'd1;
        end
      end
      S_CHK_LOW: begin
        if (sync2_q) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          f_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LOW: begin
        if (sync2_q) begin
          state_d = S_CHK_HIGH;
          cnt_d   = 16'd1;
        end else begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
          if (rpt_q == RPT_FIRE) begin
            rpt_d = RPT_RELOAD;
            f_d   = 1'b1;
          end else begin
            rpt_d = rpt_q + 26'd1;
          end
`endif
        end
      end
      S_CHK_HIGH: begin
        if (!sync2_q) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          r_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_HIGH;
        cnt_d   = '0;
        level_d = 1'b1;
      end
    endcase
  end

  assign bus.level    = level_q;
  assign bus.f_edge   = f_q;
  assign bus.r_edge   = r_q;
  assign bus.bouncing = (cnt_q != 16'd0);

endmodule

// File: tb/tb_btn_debounce_edge.sv
// Directed bench for btn_debounce_edge with STABLE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_btn_debounce_edge;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  btn_debounce_edge_if bus ();

  btn_debounce_edge #(
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // expected = {level, f_edge, r_edge, bouncing}
  typedef struct {
    logic       rst_n;
    logic       btn;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [3:0] outs();
    return {bus.level, bus.f_edge, bus.r_edge, bus.bouncing};
  endfunction

  function automatic void chk(string name, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void add(logic r, logic b, logic [3:0] e);
    vec_t v;
    v.rst_n = r;
    v.btn   = b;
    v.exp   = e;
    tbl.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ar;
    logic [3:0] exp;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    ar = 1'b1;
`else
    ar = 1'b0;
`endif
    rst_n      = 1'b0;
    bus.btn_in = 1'b1;

    // reset, clean press, clean release, 3-cycle glitch
    add(0, 1, 4'b1000); add(0, 1, 4'b1000);
    add(1, 1, 4'b1000); add(1, 1, 4'b1000);
    add(1, 1, 4'b1000); add(1, 1, 4'b1000);
    add(1, 0, 4'b1000); add(1, 0, 4'b1000);
    add(1, 0, 4'b1001); add(1, 0, 4'b1001);
    add(1, 0, 4'b1001); add(1, 0, 4'b0100);
    add(1, 0, 4'b0000); add(1, 1, 4'b0000);
    add(1, 1, 4'b0000); add(1, 1, 4'b0001);
    add(1, 1, 4'b0001); add(1, 1, 4'b0001);
    add(1, 1, 4'b1010); add(1, 1, 4'b1000);
    add(1, 0, 4'b1000); add(1, 0, 4'b1000);
    add(1, 0, 4'b1001); add(1, 1, 4'b1001);
    add(1, 1, 4'b1001); add(1, 1, 4'b1000);
    add(1, 1, 4'b1000);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n      = tbl[i].rst_n;
      bus.btn_in = tbl[i].btn;
      tick();
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // idle high after reset
    rst_n = 1'b0;
    tick();
    chk("rst_state", outs(), 4'b1000);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk("idle_high", outs(), 4'b1000);
    end

    // bounce 0,1,0,1,0 then held low
    bus.btn_in = 1'b0; tick();
    bus.btn_in = 1'b1; tick();
    bus.btn_in = 1'b0; tick();
    bus.btn_in = 1'b1; tick();
    bus.btn_in = 1'b0; tick();
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("bounce_press_f", {3'b0, bus.f_edge}, {3'b0, k == 5});
      chk("bounce_level", {3'b0, bus.level}, {3'b0, k < 5});
    end
    bus.btn_in = 1'b1; tick();
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("bounce_rel_r", {2'b0, bus.f_edge, bus.r_edge},
          {3'b0, k == 5});
    end

    // reset mid-count with counter at 3
    bus.btn_in = 1'b0; tick();
    for (int k = 1; k <= 4; k++) tick();
    chk("pre_rst_bouncing", outs(), 4'b1001);
    rst_n = 1'b0; tick();
    chk("mid_rst_state", outs(), 4'b1000);
    rst_n = 1'b1; tick();
    chk("rst_release", outs(), 4'b1000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("post_rst_f", {3'b0, bus.f_edge}, {3'b0, k == 5});
    end
    bus.btn_in = 1'b1; tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("post_rst_r", {3'b0, bus.r_edge}, {3'b0, k == 5});
    end

    // long hold: auto-repeat (or single pulse without it)
    bus.btn_in = 1'b0; tick();
    for (int k = 1; k <= 5; k++) tick();
    chk("hold_press", outs(), 4'b0100);
    for (int j = 1; j <= 70; j++) begin
      logic rep;
      bus.btn_in = (j >= 57);
      tick();
      rep = ar && (j >= 20) && (j <= 52) && ((j - 20) % 8 == 0);
      exp = {1'b0, rep, j == 62, 1'b0};
      chk($sformatf("hold_j%0d", j), {1'b0, bus.f_edge, bus.r_edge, 1'b0},
          exp);
    end
    chk("final_level", {3'b0, bus.level}, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce_edge.md
BTN_DEBOUNCE_EDGE -- requirements
Module: btn_debounce_edge

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 50000: number of consecutive cycles the synchronised input must differ from the debounced level before the level changes; legal range 2..65535.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000: cycles of continuous debounced-low before the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port btn_in, input, 1: raw asynchronous pushbutton, active-low (pressed = 0).
REQ-007 SHALL have port level, output, 1: debounced, synchronised button level.
REQ-008 SHALL have port f_edge, output, 1: one-cycle pulse on debounced high-to-low transition (press), plus auto-repeat pulses when enabled.
REQ-009 SHALL have port r_edge, output, 1: one-cycle pulse on debounced low-to-high transition (release).
REQ-010 SHALL have port bouncing, output, 1: high while the stability counter is non-zero.

Function
REQ-011 SHALL pass btn_in through a 2-flop synchroniser; only the second flop (sync) feeds the logic.
REQ-012 SHALL run a 4-state FSM: HIGH (level=1, sync=1), CHK_LOW (level=1, counting sync=0), LOW (level=0, sync=0), CHK_HIGH (level=0, counting sync=1).
REQ-013 HIGH->CHK_LOW when sync=0, counter loads 1; LOW->CHK_HIGH when sync=1, counter loads 1.
REQ-014 In CHK_* state, counter increments each cycle sync differs from level; any cycle sync equals level clears counter and returns to HIGH/LOW respectively, no pulse.
REQ-015 When counter = STABLE_CYCLES-1 and sync still differs, next cycle SHALL toggle level, clear counter, enter LOW/HIGH, and assert f_edge (to LOW) or r_edge (to HIGH) for exactly that one cycle.
REQ-016 Latency: a clean change on btn_in first sampled at edge N SHALL produce level change and edge pulse registered at edge N+1+STABLE_CYCLES.
REQ-017 Counter width SHALL be 16 bits; counter SHALL never wrap (bounded by REQ-015).
REQ-018 f_edge and r_edge SHALL never be high in the same cycle; pulses SHALL be registered outputs, no combinational path from btn_in.

Reset
REQ-019 While rst_n=0 at a clk edge: both synchroniser flops=1, FSM=HIGH, level=1, f_edge=0, r_edge=0, bouncing=0, stability and repeat counters=0.
REQ-020 Reset asserted mid-count SHALL discard the pending transition; no pulse is emitted on or after reset release unless REQ-015 is satisfied afresh.

Configuration
REQ-021 With macro DEBOUNCE_AUTOREPEAT_EN defined: while in LOW, a repeat counter SHALL count cycles; at REPEAT_DELAY cycles after the press pulse a one-cycle f_edge SHALL be emitted, then one every REPEAT_PERIOD cycles until leaving LOW.
REQ-022 With DEBOUNCE_AUTOREPEAT_EN defined: repeat counter (26 bits) SHALL clear on entering CHK_HIGH and on reset; an auto-repeat pulse SHALL be suppressed while in CHK_HIGH.
REQ-023 Without DEBOUNCE_AUTOREPEAT_EN: no repeat counter is synthesised, REPEAT_DELAY/REPEAT_PERIOD are ignored, f_edge pulses exactly once per debounced press.

Verification (STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-024 Reset then btn_in held 1 for 50 cycles -> level=1, f_edge=r_edge=bouncing=0 throughout.
REQ-025 btn_in 1->0 clean at edge 10 -> level=0 and single f_edge pulse registered at edge 15; bouncing high edges 12..14.
REQ-026 btn_in glitches 0 for 3 cycles then 1 -> no pulse, level stays 1, FSM returns HIGH.
REQ-027 Bounce 0,1,0,1,0 then held 0 -> exactly one f_edge, 5 cycles after final stable 0 sampled; later release -> exactly one r_edge.
REQ-028 rst_n=0 for 1 cycle when counter=3 in CHK_LOW -> no f_edge; level=1 after reset; held 0 then yields f_edge 5 cycles after release of reset.
REQ-029 AUTOREPEAT_EN, hold 0 for 60 cycles after press pulse at cycle P -> f_edge at P, P+20, P+28, P+36, P+44, P+52; none after release starts.
